// File: rtl/arm_pkg.sv
// Shared ARM definitions: ALU opcodes, condition codes, slot states and
// opcode classification helpers used by the flag stage.
package arm_pkg;

  // Data-processing opcodes (shared ALU encoding)
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  // Condition field encodings
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Write-back slot states
  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  // Architectural flags, packed in {N,Z,C,V} order
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Arithmetic ops take all four flags from the ALU adder
  function automatic logic is_arith(input logic [3:0] op);
    return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Compare/test ops always update flags and never write a register
  function automatic logic is_cmp(input logic [3:0] op);
    return (op >= OP_TST) && (op <= OP_CMN);
  endfunction

endpackage

// File: rtl/alu_flag_stage_cond_check.sv
// Condition-field evaluator: decides whether an instruction executes given
// the committed NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  // Map each ARM condition code onto its flag predicate
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Flag stage behind the ALU: owns the committed NZCV flags, gates each
// instruction on its condition field, commits flag updates and holds the
// result in a one-entry write-back slot.
module alu_flag_stage
  import arm_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [3:0]       in_cond,
  input  logic             in_s,
  input  logic [3:0]       in_rd,
  input  logic [DW-1:0]    in_result,
  input  logic             in_nf,
  input  logic             in_zf,
  input  logic             in_cf,
  input  logic             in_vf,
  input  logic             in_shc,
  output logic             alu_cin,
  output logic [3:0]       flags,
  input  logic             flag_we,
  input  logic [3:0]       flag_wdata,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [3:0]       wb_rd,
  output logic [DW-1:0]    wb_data,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  nzcv_t      flag_q;
  nzcv_t      flag_nxt;
  logic [0:0] slot_state;
  logic       pass;
  logic       accept;
  logic       executes;
  logic       load;
  logic       drain;
  logic       upd_flags;

  cond_check u_cond_check (
    .cond (in_cond),
    .nzcv (flag_q),
    .pass (pass)
  );

  assign flags     = flag_q;
  assign alu_cin   = flag_q.c;
  assign wb_valid  = (slot_state == SLOT_FULL);
  assign in_ready  = !wb_valid || wb_ready;
  assign accept    = in_valid && in_ready;
  assign executes  = accept && pass;
  assign load      = executes && !is_cmp(in_op);
  assign drain     = wb_valid && wb_ready;
  assign upd_flags = executes && (in_s || is_cmp(in_op));

  // Compute the flag value an executing instruction would commit
  always_comb begin
    flag_nxt = flag_q;
    if (is_arith(in_op)) begin
      flag_nxt = '{n: in_nf, z: in_zf, c: in_cf, v: in_vf};
    end else begin
      flag_nxt.n = in_nf;
      flag_nxt.z = in_zf;
      flag_nxt.c = in_shc;
    end
  end

  // Commit flags; a direct flag write overrides any instruction update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= '0;
    end else if (flag_we) begin
      flag_q <= flag_wdata;
    end else if (upd_flags) begin
      flag_q <= flag_nxt;
    end
  end

  // Slot occupancy: fill wins over drain so drain+fill stays full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_state <= SLOT_EMPTY;
    end else if (load) begin
      slot_state <= SLOT_FULL;
    end else if (drain) begin
      slot_state <= SLOT_EMPTY;
    end
  end

  // Slot payload only changes on a load and is otherwise held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (load) begin
      wb_rd   <= in_rd;
      wb_data <= in_result;
    end
  end

  // Count accepted instructions by condition outcome, wrapping freely
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt <= '0;
      skip_cnt <= '0;
    end else if (accept) begin
      if (pass) begin
        exec_cnt <= exec_cnt + CNT_ONE;
      end else begin
        skip_cnt <= skip_cnt + CNT_ONE;
      end
    end
  end

endmodule
